// File: rtl/iobus_responder_if.sv
// iobus_responder_if -- CPU memory-mapped I/O bus bundle.
//   IOBUS_ADDR  CPU byte address            (master -> slave)
//   IOBUS_OUT   CPU write data              (master -> slave)
//   IOBUS_WR    one-cycle store strobe      (master -> slave)
//   IOBUS_RD    one-cycle load strobe       (master -> slave)
//   IOBUS_IN    registered read data        (slave -> master)
//   INTR        level interrupt request     (slave -> master)
interface iobus_responder_if;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic        IOBUS_RD;
    logic [31:0] IOBUS_IN;
    logic        INTR;

    modport master (
        output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, IOBUS_RD,
        input  IOBUS_IN, INTR
    );

    modport slave (
        input  IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, IOBUS_RD,
        output IOBUS_IN, INTR
    );
endinterface

// File: rtl/iobus_responder.sv
// iobus_responder -- memory-mapped switch/LED/timer peripheral.
// Word map relative to BASE_ADDR (32-byte window):
//   0x00 SW     (RO)  synchronized switches, zero-extended
//   0x04 LED    (RW)  drives LEDS
//   0x08 CTRL   (RW)  bit0 EN, bit1 AUTO, bit2 IRQEN
//   0x0C LOAD   (RW)  writing also loads COUNT
//   0x10 COUNT  (RO)  down-counter
//   0x14 STATUS (W1C) bit0 PEND
// Ports:
//   CLK, RESET_N  clock (rising edge) and async active-low reset
//   bus           iobus_responder_if.slave (address/data/strobes, read data, INTR)
//   SWITCHES      asynchronous board switches
//   LEDS          registered LED drive
module iobus_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int          SW_WIDTH  = 16,
    parameter int          LED_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    iobus_responder_if.slave     bus,
    input  logic [SW_WIDTH-1:0]  SWITCHES,
    output logic [LED_WIDTH-1:0] LEDS
);

    // word index (address bits [4:2])
    localparam logic [2:0] IDX_SW     = 3'd0;
    localparam logic [2:0] IDX_LED    = 3'd1;
    localparam logic [2:0] IDX_CTRL   = 3'd2;
    localparam logic [2:0] IDX_LOAD   = 3'd3;
    localparam logic [2:0] IDX_COUNT  = 3'd4;
    localparam logic [2:0] IDX_STATUS = 3'd5;

    logic [SW_WIDTH-1:0]  sw_s1_q, sw_s2_q;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [2:0]           ctrl_q, ctrl_d;
    logic [31:0]          load_q, load_d;
    logic [31:0]          count_q, count_d;
    logic                 pend_q, pend_d;
    logic [31:0]          rdata_q, rdata_d;

    logic        hit;
    logic [2:0]  idx;
    logic [31:0] wdata;
    logic [31:0] rd_val;
    logic        wr_led, wr_ctrl, wr_load, wr_status;
    logic        expire;

    assign hit   = (bus.IOBUS_ADDR[31:5] == BASE_ADDR[31:5]) && (bus.IOBUS_ADDR[1:0] == 2'b00);
    assign idx   = bus.IOBUS_ADDR[4:2];
    assign wdata = bus.IOBUS_OUT;

    assign wr_led    = bus.IOBUS_WR && hit && (idx == IDX_LED);
    assign wr_ctrl   = bus.IOBUS_WR && hit && (idx == IDX_CTRL);
    assign wr_load   = bus.IOBUS_WR && hit && (idx == IDX_LOAD);
    assign wr_status = bus.IOBUS_WR && hit && (idx == IDX_STATUS);

    // Read mux sees only pre-edge register values, so a same-cycle write
    // to the addressed register returns the old value.
    always_comb begin
        rd_val = '0;
        if (hit) begin
            case (idx)
                IDX_SW:     rd_val = 32'(sw_s2_q);
                IDX_LED:    rd_val = 32'(led_q);
                IDX_CTRL:   rd_val = {29'd0, ctrl_q};
                IDX_LOAD:   rd_val = load_q;
                IDX_COUNT:  rd_val = count_q;
                IDX_STATUS: rd_val = {31'd0, pend_q};
                default:    rd_val = '0;
            endcase
        end
    end

    assign rdata_d = bus.IOBUS_RD ? rd_val : rdata_q;

    // Timer and register next state. Later assignments carry priority:
    // LOAD write beats decrement/reload, expiry set beats W1C, and one-shot
    // EN clear beats a CTRL write on bit0 only.
    always_comb begin
        expire = ctrl_q[0] && (count_q == 32'd0);

        led_d  = wr_led  ? wdata[LED_WIDTH-1:0] : led_q;
        load_d = wr_load ? wdata : load_q;

        count_d = count_q;
        if (ctrl_q[0]) begin
            if (count_q != 32'd0) count_d = count_q - 32'd1;
            else if (ctrl_q[1])   count_d = load_q;
        end
        if (wr_load) count_d = wdata;

        ctrl_d = ctrl_q;
        if (wr_ctrl) ctrl_d = wdata[2:0];
        if (expire && !ctrl_q[1]) ctrl_d[0] = 1'b0;

        pend_d = pend_q;
        if (wr_status && wdata[0]) pend_d = 1'b0;
        if (expire) pend_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            led_q   <= '0;
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            sw_s1_q <= SWITCHES;
            sw_s2_q <= sw_s1_q;
            led_q   <= led_d;
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            rdata_q <= rdata_d;
        end
    end

    assign LEDS         = led_q;
    assign bus.IOBUS_IN = rdata_q;
    assign bus.INTR     = pend_q & ctrl_q[2];

endmodule

// File: tb/tb_iobus_responder.sv
// tb_iobus_responder -- directed scenarios plus randomized bus traffic,
// checked each cycle against a register-level reference model.
module tb_iobus_responder;

    localparam logic [31:0] BASE = 32'h1100_0000;
    localparam int SW_W  = 16;
    localparam int LED_W = 16;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic [SW_W-1:0]  SWITCHES = '0;
    logic [LED_W-1:0] LEDS;

    iobus_responder_if bus ();

    iobus_responder #(.BASE_ADDR(BASE), .SW_WIDTH(SW_W), .LED_WIDTH(LED_W)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .bus      (bus),
        .SWITCHES (SWITCHES),
        .LEDS     (LEDS)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_sw1, m_sw2, m_led, m_load, m_count, m_rdata;
    bit          m_en, m_auto, m_irqen, m_pend;

    task automatic mdl_reset();
        m_sw1 = 0; m_sw2 = 0; m_led = 0; m_load = 0; m_count = 0; m_rdata = 0;
        m_en = 0; m_auto = 0; m_irqen = 0; m_pend = 0;
    endtask

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        if (a[31:5] != BASE[31:5] || a[1:0] != 2'b00) return 32'd0;
        case (a[4:0])
            5'h00: return m_sw2;
            5'h04: return m_led;
            5'h08: return {29'd0, m_irqen, m_auto, m_en};
            5'h0C: return m_load;
            5'h10: return m_count;
            5'h14: return {31'd0, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge: everything computed from the state before the edge.
    task automatic mdl_step(input logic [31:0] a, input logic [31:0] d, input bit wr, input bit rd);
        bit hit   = (a[31:5] == BASE[31:5]) && (a[1:0] == 2'b00);
        bit fired = m_en && (m_count == 0);
        bit one_shot_done = fired && !m_auto;
        logic [31:0] nxt_count = m_count;
        bit nxt_en = m_en;
        bit nxt_pend = m_pend;
        if (rd) m_rdata = mdl_read(a);
        // timer on its own
        if (m_en) begin
            if (m_count > 0) nxt_count = m_count - 1;
            else nxt_count = m_auto ? m_load : 0;
        end
        if (one_shot_done) nxt_en = 0;
        // software writes
        if (wr && hit) begin
            case (a[4:0])
                5'h04: m_led = d & ((32'd1 << LED_W) - 1);
                5'h08: begin m_irqen = d[2]; m_auto = d[1]; nxt_en = d[0] && !one_shot_done; end
                5'h0C: begin m_load = d; nxt_count = d; end
                5'h14: if (d[0]) nxt_pend = 0;
                default: ;
            endcase
        end
        if (fired) nxt_pend = 1;
        m_count = nxt_count; m_en = nxt_en; m_pend = nxt_pend;
        m_sw2 = m_sw1;
        m_sw1 = 32'(SWITCHES);
    endtask

    // Drive one bus cycle from a negedge, step the model at the posedge,
    // compare just after it, and return at the next negedge.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input bit wr, input bit rd);
        bus.IOBUS_ADDR = a; bus.IOBUS_OUT = d; bus.IOBUS_WR = wr; bus.IOBUS_RD = rd;
        @(posedge CLK);
        mdl_step(a, d, wr, rd);
        #1;
        chk("rdata", bus.IOBUS_IN, m_rdata);
        chk("leds", 32'(LEDS), m_led);
        chk("intr", 32'(bus.INTR), 32'(m_pend & m_irqen));
        @(negedge CLK);
    endtask

    task automatic idle();  cyc(32'd0, 32'd0, 0, 0); endtask
    task automatic wr32(input logic [31:0] off, input logic [31:0] d); cyc(BASE + off, d, 1, 0); endtask
    task automatic rd32(input logic [31:0] a);  cyc(a, 32'd0, 0, 1); endtask

    initial begin
        bus.IOBUS_ADDR = 0; bus.IOBUS_OUT = 0; bus.IOBUS_WR = 0; bus.IOBUS_RD = 0;
        mdl_reset();
        #1;
        chk("rst_rdata", bus.IOBUS_IN, 32'd0);
        chk("rst_leds", 32'(LEDS), 32'd0);
        chk("rst_intr", 32'(bus.INTR), 32'd0);
        @(negedge CLK); @(negedge CLK);
        RESET_N = 1'b1;

        // LED write then read
        wr32(32'h04, 32'h0000_A5A5);
        chk("led_after_wr", 32'(LEDS), 32'h0000_A5A5);
        rd32(BASE + 32'h04);
        chk("led_read", bus.IOBUS_IN, 32'h0000_A5A5);

        // switch sync, misaligned and out-of-window reads
        SWITCHES = 16'h1234;
        idle(); idle(); idle();
        rd32(BASE);
        chk("sw_read", bus.IOBUS_IN, 32'h0000_1234);
        rd32(BASE + 32'h02);
        chk("misaligned_read", bus.IOBUS_IN, 32'd0);
        rd32(BASE + 32'h20);
        chk("nonhit_read", bus.IOBUS_IN, 32'd0);
        wr32(32'h00, 32'hFFFF_FFFF);   // RO, ignored
        wr32(32'h18, 32'hFFFF_FFFF);   // unmapped, ignored
        cyc(BASE + 32'h06, 32'h1, 1, 0); // misaligned, ignored
        chk("led_unchanged", 32'(LEDS), 32'h0000_A5A5);

        // one-shot timer
        wr32(32'h0C, 32'd3);
        wr32(32'h08, 32'h5);
        rd32(BASE + 32'h10); chk("os_cnt3", bus.IOBUS_IN, 32'd3);
        rd32(BASE + 32'h10); chk("os_cnt2", bus.IOBUS_IN, 32'd2);
        rd32(BASE + 32'h10); chk("os_cnt1", bus.IOBUS_IN, 32'd1);
        rd32(BASE + 32'h10); chk("os_cnt0", bus.IOBUS_IN, 32'd0);
        chk("os_intr", 32'(bus.INTR), 32'd1);
        rd32(BASE + 32'h08); chk("os_en_clr", bus.IOBUS_IN, 32'h4);
        rd32(BASE + 32'h14); chk("os_pend", bus.IOBUS_IN, 32'd1);
        wr32(32'h14, 32'd1);
        chk("os_w1c", 32'(bus.INTR), 32'd0);

        // auto-reload timer
        wr32(32'h0C, 32'd2);
        wr32(32'h08, 32'h7);
        idle(); idle();
        wr32(32'h14, 32'd1);           // lands on the expiry edge
        chk("ar_pend_kept", 32'(bus.INTR), 32'd1);
        wr32(32'h14, 32'd1);
        chk("ar_w1c", 32'(bus.INTR), 32'd0);
        idle(); chk("ar_gap", 32'(bus.INTR), 32'd0);
        idle(); chk("ar_period", 32'(bus.INTR), 32'd1);
        rd32(BASE + 32'h10); chk("ar_reload", bus.IOBUS_IN, 32'd2);
        wr32(32'h08, 32'h0);
        wr32(32'h14, 32'd1);

        // simultaneous read/write
        wr32(32'h04, 32'h1);
        cyc(BASE + 32'h04, 32'h2, 1, 1);
        chk("rw_old", bus.IOBUS_IN, 32'h1);
        chk("rw_new", 32'(LEDS), 32'h2);

        // reset mid-count
        wr32(32'h0C, 32'd8);
        wr32(32'h08, 32'h5);
        idle(); idle(); idle();
        #2 RESET_N = 1'b0;
        #1;
        mdl_reset();
        chk("amid_rdata", bus.IOBUS_IN, 32'd0);
        chk("amid_leds", 32'(LEDS), 32'd0);
        chk("amid_intr", 32'(bus.INTR), 32'd0);
        #1 RESET_N = 1'b1;
        for (int i = 0; i < 12; i++) idle();
        rd32(BASE + 32'h10); chk("post_rst_cnt", bus.IOBUS_IN, 32'd0);
        rd32(BASE + 32'h08); chk("post_rst_ctrl", bus.IOBUS_IN, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, d;
            logic [31:0] off;
            bit wr, rd;
            int r;
            r   = $urandom_range(0, 9);
            off = 32'($urandom_range(0, 7)) * 4;
            a   = BASE + off;
            if (r == 0) a = BASE + 32'($urandom_range(0, 31));
            if (r == 1) a = $urandom();
            d  = $urandom();
            if (off == 32'h0C) d = 32'($urandom_range(0, 6));
            wr = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) SWITCHES = 16'($urandom());
            cyc(a, d, wr, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
